// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sa_state_e;

  localparam int SA_WIDTH_DEF = 8;

  // Bit counter must reach WIDTH-1; keep at least one bit.
  function automatic int sa_cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/halfadder.sv
// One-bit half adder: sum and carry of two inputs.
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_full_adder_cell.sv
// Full-adder cell built from two half adders and an OR of their carries.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic s0, c0, c1;

  halfadder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  halfadder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

  assign co = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, valid/ready on both sides.
// Optional SERIAL_ADDER_SUB_EN adds a 'sub' input for a-b via ~b and carry-in 1.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = sa_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] reg_a_q, reg_a_d;
  logic [WIDTH-1:0] reg_b_q, reg_b_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic sub_i;
  logic fa_s, fa_co;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif

  full_adder_cell u_fa (
    .a   (reg_a_q[0]),
    .b   (reg_b_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      reg_a_q  <= '0;
      reg_b_q  <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      reg_a_q  <= reg_a_d;
      reg_b_q  <= reg_b_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    reg_a_d  = reg_a_q;
    reg_b_d  = reg_b_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          reg_a_d  = a;
          reg_b_d  = sub_i ? ~b : b;
          carry_d  = sub_i;
          cnt_d    = '0;
          sum_sh_d = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        reg_a_d  = {1'b0, reg_a_q[WIDTH-1:1]};
        reg_b_d  = {1'b0, reg_b_q[WIDTH-1:1]};
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_co;
        cnt_d    = cnt_q + 1'b1;
        // Visible sum/cout only update here, so they hold between operations.
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
          cout_d  = fa_co;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8: vector table plus handshake corner cases.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk, rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         sub;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands, wait for accept, then count edges (accept edge included) to out_valid.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                          output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    a = ta; b = tb_; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      errors++;
      $display("FAIL out_valid_timeout: no out_valid within %0d edges", lat);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    out_ready = 1'b1;
    start_op(v.a, v.b, v.sub, lat);
    chk({tag, "_latency"}, 64'(lat), 64'(W + 1));
    chk({tag, "_sum"}, {56'd0, sum}, {56'd0, v.exp_sum});
    chk({tag, "_cout"}, {63'd0, cout}, {63'd0, v.exp_cout});
    @(posedge clk); #1;
    chk({tag, "_idle_after"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;

    vecs.push_back('{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
    vecs.push_back('{8'h12, 8'h34, 1'b0, 8'h46, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1});
    vecs.push_back('{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0});
    vecs.push_back('{8'h05, 8'h05, 1'b1, 8'h00, 1'b1});
    vecs.push_back('{8'h10, 8'h01, 1'b0, 8'h11, 1'b0});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
    chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
    chk("idle_sum", {56'd0, sum}, 64'd0);
    chk("idle_cout", {63'd0, cout}, 64'd0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held for 5 cycles, in_valid ignored while busy.
    out_ready = 1'b0;
    start_op(8'h80, 8'h80, 1'b0, lat);
    chk("bp_latency", 64'(lat), 64'(W + 1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 1);
      a = 8'h11; b = 8'h11;
      chk($sformatf("bp_valid_%0d", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("bp_in_ready_%0d", i), {63'd0, in_ready}, 64'd0);
      chk($sformatf("bp_sum_%0d", i), {56'd0, sum}, 64'h00);
      chk($sformatf("bp_cout_%0d", i), {63'd0, cout}, 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    chk("bp_hold_sum", {56'd0, sum}, 64'h00);
    chk("bp_hold_cout", {63'd0, cout}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_no_spurious_op", {62'd0, out_valid, in_ready}, 64'b01);

    // Reset during the 4th SHIFT cycle aborts the operation.
    @(negedge clk);
    a = 8'hAA; b = 8'h55; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_shift_busy", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_sum", {56'd0, sum}, 64'h00);
    chk("abort_cout", {63'd0, cout}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    run_vec('{8'h01, 8'h02, 1'b0, 8'h03, 1'b0}, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
